ex_md_unit: RTL and testbench

- Multiply/divide and HI/LO unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the one-hot MD opcode and the rs/rt operands registered by ID/EX.
- Owns the architectural HI/LO registers and returns MFHI/MFLO data.
- Multiply is single-cycle. Divide is a 32-iteration restoring divider; while it runs, md_stall holds the pipeline (it is ORed into EX_stall).

---
 rtl/ex_md_unit_pkg.sv | 22 ++
 rtl/ex_md_unit_if.sv | 23 ++
 rtl/ex_md_unit_div_iter.sv | 82 ++++++++
 rtl/ex_md_unit.sv | 109 ++++++++++
 tb/tb_ex_md_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: md_op bit indices,
// FSM state encoding and the default divide iteration count.
package md_pkg;

  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MFHI  = 4;
  localparam int unsigned MD_MFLO  = 5;
  localparam int unsigned MD_MTHI  = 6;
  localparam int unsigned MD_MTLO  = 7;

  localparam int unsigned MD_DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_md_unit_if.sv
// EX-stage view of the MD unit: opcode/operands and pipeline controls in,
// stall, move-from result and architectural HI/LO out.
interface ex_md_unit_if;
  logic [7:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ex_hold;
  logic        flush;
  logic        md_stall;
  logic [31:0] md_result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, rs_data, rt_data, ex_hold, flush,
    input  md_stall, md_result, hi, lo
  );

  modport slave (
    input  md_op, rs_data, rt_data, ex_hold, flush,
    output md_stall, md_result, hi, lo
  );
endinterface

// File: rtl/ex_md_unit_div_iter.sv
// Radix-2 restoring divider on magnitudes with sign fixup on the outputs.
// Optional MD_DIV_EARLY_OUT_EN: flags B==0 or |A|<|B| so the FSM can skip iterating.
module div_iter
  import md_pkg::*;
#(
  parameter int unsigned DIV_ITERS = MD_DIV_ITERS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        early,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CW = $clog2(DIV_ITERS) + 1;

  logic [63:0]   rem;
  logic [63:0]   rem_next;
  logic [31:0]   dvsr;
  logic [CW-1:0] count;
  logic          sa, sb, bz;

  logic          a_neg, b_neg, b_zero;
  logic [31:0]   abs_a, abs_b;
  logic [32:0]   top;
  logic          fits;
  logic [31:0]   sub;

  assign a_neg  = signed_op & a[31];
  assign b_neg  = signed_op & b[31];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;
  assign b_zero = (b == '0);

`ifdef MD_DIV_EARLY_OUT_EN
  assign early = b_zero | (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // Shifted partial remainder can reach 33 bits; the compare uses all of it,
  // while the difference always fits back into 32 bits.
  assign top      = rem[63:31];
  assign fits     = (top >= {1'b0, dvsr});
  assign sub      = top[31:0] - dvsr;
  assign rem_next = {fits ? sub : top[31:0], rem[30:0], fits};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem   <= '0;
      dvsr  <= '0;
      count <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      bz    <= 1'b0;
    end else if (start) begin
      dvsr  <= abs_b;
      count <= '0;
      sa    <= a_neg;
      sb    <= b_neg;
      bz    <= b_zero;
      // Early-out preloads the final restoring result: quotient 0 or all-ones.
      rem   <= early ? {abs_a, {32{b_zero}}} : {32'd0, abs_a};
    end else if (step) begin
      rem   <= rem_next;
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(DIV_ITERS - 1));

  // Divide-by-zero keeps the raw all-ones quotient regardless of operand sign.
  assign quotient  = ((sa ^ sb) & ~bz) ? -rem[31:0] : rem[31:0];
  assign remainder = sa ? -rem[63:32] : rem[63:32];

endmodule

// File: rtl/ex_md_unit.sv
// EX-stage multiply/divide unit owning HI/LO: single-cycle mult/multu/mthi/mtlo,
// multi-cycle divide with md_stall. Optional MD_DIV_EARLY_OUT_EN shortens trivial divides.
module ex_md_unit
  import md_pkg::*;
#(
  parameter int unsigned DIV_ITERS = MD_DIV_ITERS
) (
  input logic         clk,
  input logic         resetn,
  ex_md_unit_if.slave md
);

  md_state_e   state, next_state;
  logic        div_start, div_step, div_wr;
  logic        div_early, div_last;
  logic [31:0] div_q, div_r;
  logic [31:0] hi_q, lo_q;
  logic        is_div, single_ok;
  logic [63:0] op_a, op_b, prod;

  assign is_div = md.md_op[MD_DIV] | md.md_op[MD_DIVU];

  div_iter #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (div_step),
    .signed_op (md.md_op[MD_DIV]),
    .a         (md.rs_data),
    .b         (md.rt_data),
    .early     (div_early),
    .last      (div_last),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state  = state;
    md.md_stall = 1'b0;
    div_start   = 1'b0;
    div_step    = 1'b0;
    div_wr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_div && !md.flush) begin
          md.md_stall = 1'b1;
          div_start   = 1'b1;
          next_state  = div_early ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        md.md_stall = 1'b1;
        div_step    = 1'b1;
        if (md.flush)     next_state = ST_IDLE;
        else if (div_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (md.flush) begin
          next_state = ST_IDLE;
        end else if (!md.ex_hold) begin
          div_wr     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // One 64x64 multiplier serves both forms; sign extension selects mult vs multu.
  assign op_a = {{32{md.md_op[MD_MULT] & md.rs_data[31]}}, md.rs_data};
  assign op_b = {{32{md.md_op[MD_MULT] & md.rt_data[31]}}, md.rt_data};
  assign prod = op_a * op_b;

  assign single_ok = (state == ST_IDLE) && !md.flush && !md.ex_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_wr) begin
      hi_q <= div_r;
      lo_q <= div_q;
    end else if (single_ok) begin
      if (md.md_op[MD_MULT] || md.md_op[MD_MULTU]) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end
      if (md.md_op[MD_MTHI]) hi_q <= md.rs_data;
      if (md.md_op[MD_MTLO]) lo_q <= md.rs_data;
    end
  end

  always_comb begin
    md.md_result = '0;
    if (md.md_op[MD_MFHI])      md.md_result = hi_q;
    else if (md.md_op[MD_MFLO]) md.md_result = lo_q;
  end

  assign md.hi = hi_q;
  assign md.lo = lo_q;

endmodule

// File: tb/tb_ex_md_unit.sv
// Directed bench for ex_md_unit: expected HI/LO pushed to a scoreboard at issue,
// popped when the write lands; stall lengths and flush/hold/reset cases checked inline.
module tb_ex_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ex_md_unit_if mif ();

  ex_md_unit #(
    .DIV_ITERS (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (mif)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

`ifdef MD_DIV_EARLY_OUT_EN
  localparam int EARLY_STALL = 1;
`else
  localparam int EARLY_STALL = 33;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, mif.hi, e.hi);
      chk({e.tag, "_lo"}, mif.lo, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic single(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    mif.md_op   = op;
    mif.rs_data = a;
    mif.rt_data = b;
    sb.push_back('{tag, ehi, elo});
    #1;
    chk({tag, "_stall"}, {31'd0, mif.md_stall}, 32'd0);
    tick();
    mif.md_op = '0;
    pop_check(tag);
  endtask

  // Counts md_stall cycles from issue; leaves the bench in the DONE cycle.
  task automatic div_to_done(input string tag, input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int exp_stall);
    int n;
    mif.md_op   = op;
    mif.rs_data = a;
    mif.rt_data = b;
    #1;
    n = 0;
    while (mif.md_stall && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    mif.md_op = '0;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int exp_stall);
    sb.push_back('{tag, ehi, elo});
    div_to_done(tag, op, a, b, exp_stall);
    chk({tag, "_nowrite_before_done"}, mif.lo, m_lo);
    tick();
    pop_check(tag);
  endtask

  initial begin
    resetn      = 1'b0;
    mif.md_op   = '0;
    mif.rs_data = '0;
    mif.rt_data = '0;
    mif.ex_hold = 1'b0;
    mif.flush   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("rst_hi", mif.hi, 32'd0);
    chk("rst_lo", mif.lo, 32'd0);
    chk("rst_stall", {31'd0, mif.md_stall}, 32'd0);
    chk("rst_result", mif.md_result, 32'd0);

    single("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    single("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
    single("mult_maxpos", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    single("multu_ffx2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

    mif.md_op = OP_MFHI;
    #1;
    chk("mfhi", mif.md_result, 32'h0000_0001);
    tick();
    mif.md_op = OP_MFLO;
    #1;
    chk("mflo", mif.md_result, 32'hFFFF_FFFE);
    tick();
    mif.md_op = '0;
    #1;
    chk("result_idle", mif.md_result, 32'd0);

    single("multu_ffxff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_div("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, EARLY_STALL);
    run_div("div_by0_neg", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, EARLY_STALL);
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    run_div("divu_small", OP_DIVU, 32'd3, 32'd10, 32'd3, 32'd0, EARLY_STALL);

    single("mthi", OP_MTHI, 32'h0000_0055, 32'd0, 32'h0000_0055, m_lo);

    // Flush in IDLE suppresses the issue-cycle stall and the divide start.
    mif.md_op   = OP_DIV;
    mif.rs_data = 32'd50;
    mif.rt_data = 32'd5;
    mif.flush   = 1'b1;
    #1;
    chk("flush_idle_stall", {31'd0, mif.md_stall}, 32'd0);
    tick();
    mif.md_op = '0;
    mif.flush = 1'b0;
    #1;
    chk("flush_idle_nostart", {31'd0, mif.md_stall}, 32'd0);

    // Flush on the 10th BUSY cycle of div 50/5.
    mif.md_op = OP_DIV;
    #1;
    chk("flush_issue_stall", {31'd0, mif.md_stall}, 32'd1);
    repeat (10) tick();
    mif.flush = 1'b1;
    mif.md_op = '0;
    #1;
    chk("flush_busy_stall_same", {31'd0, mif.md_stall}, 32'd1);
    tick();
    mif.flush = 1'b0;
    #1;
    chk("flush_busy_stall_next", {31'd0, mif.md_stall}, 32'd0);
    chk("flush_hi_kept", mif.hi, m_hi);
    chk("flush_lo_kept", mif.lo, m_lo);
    repeat (3) tick();
    chk("flush_no_late_write", mif.lo, m_lo);
    single("mtlo_after_flush", OP_MTLO, 32'h0000_ABCD, 32'd0, m_hi, 32'h0000_ABCD);

    // ex_hold blocks a single-cycle write.
    mif.ex_hold = 1'b1;
    mif.md_op   = OP_MULT;
    mif.rs_data = 32'd2;
    mif.rt_data = 32'd3;
    tick();
    mif.md_op   = '0;
    mif.ex_hold = 1'b0;
    chk("hold_mult_hi", mif.hi, m_hi);
    chk("hold_mult_lo", mif.lo, m_lo);

    // ex_hold for 3 cycles in DONE, then one write.
    sb.push_back('{"div_hold", 32'd1, 32'd100});
    div_to_done("div_hold", OP_DIVU, 32'd1001, 32'd10, 33);
    mif.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_done_lo", mif.lo, m_lo);
      chk("hold_done_stall", {31'd0, mif.md_stall}, 32'd0);
    end
    mif.ex_hold = 1'b0;
    tick();
    pop_check("div_hold");

    // Flush wins over ex_hold in DONE.
    div_to_done("div_flush_hold", OP_DIVU, 32'd9, 32'd2, 33);
    mif.ex_hold = 1'b1;
    mif.flush   = 1'b1;
    tick();
    mif.ex_hold = 1'b0;
    mif.flush   = 1'b0;
    chk("flush_hold_lo", mif.lo, m_lo);
    tick();
    chk("flush_hold_lo_after", mif.lo, m_lo);

    // Reset in the middle of a divide.
    mif.md_op   = OP_DIV;
    mif.rs_data = 32'd50;
    mif.rt_data = 32'd5;
    repeat (5) tick();
    resetn    = 1'b0;
    mif.md_op = '0;
    tick();
    resetn = 1'b1;
    chk("midrst_hi", mif.hi, 32'd0);
    chk("midrst_lo", mif.lo, 32'd0);
    chk("midrst_stall", {31'd0, mif.md_stall}, 32'd0);
    tick();
    chk("midrst_stall_after", {31'd0, mif.md_stall}, 32'd0);
    chk("midrst_lo_after", mif.lo, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
